// File: rtl/alu_lockstep_pkg.sv
// Shared op codes and FSM state encoding for the lockstep ALU controller.
package alu_lockstep_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CMP  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_lane.sv
// Combinational WIDTH-bit ALU lane; bit WIDTH of the result carries the carry/borrow.
module alu_lane
  import alu_lockstep_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH:0]   o_res
);

  always_comb begin
    o_res = '0;
    case (i_op)
      OP_ADD:  o_res = {1'b0, i_a} + {1'b0, i_b};
      OP_SUB:  o_res = {1'b0, i_a} - {1'b0, i_b};
      OP_AND:  o_res = {1'b0, i_a & i_b};
      OP_OR:   o_res = {1'b0, i_a | i_b};
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_lockstep_ctrl.sv
// Runs each request through two ALU lanes in lockstep, retrying on disagreement.
// Optional macro ALU_LOCKSTEP_FAULT_INJECT_EN adds inj_mask, XORed into lane 2 each pass.
module alu_lockstep_ctrl
  import alu_lockstep_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_carry,
  output logic              rsp_fault,
  output logic              busy,
  output logic [FCNT_W-1:0] fault_count,
  input  logic              clr_fault_cnt
`ifdef ALU_LOCKSTEP_FAULT_INJECT_EN
  ,
  input  logic [WIDTH:0]    inj_mask
`endif
);

  localparam int unsigned RES_W   = WIDTH + 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t              r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [OP_W-1:0]     r_op;
  logic [RES_W-1:0]    r_res1;
  logic [RES_W-1:0]    r_res2;
  logic [RETRY_W-1:0]  r_retry_cnt;
  logic [FCNT_W-1:0]   r_fault_cnt;
  logic                r_req_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [WIDTH-1:0]    r_rsp_data;
  logic                r_rsp_carry;
  logic                r_rsp_fault;

  logic [RES_W-1:0]    w_lane1;
  logic [RES_W-1:0]    w_lane2;
  logic [RES_W-1:0]    w_lane2_q;
  logic                w_mismatch;
  logic                w_fcnt_sat;

  alu_lane #(.WIDTH(WIDTH)) u_lane1 (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .o_res (w_lane1)
  );

  alu_lane #(.WIDTH(WIDTH)) u_lane2 (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .o_res (w_lane2)
  );

`ifdef ALU_LOCKSTEP_FAULT_INJECT_EN
  assign w_lane2_q = w_lane2 ^ inj_mask;
`else
  assign w_lane2_q = w_lane2;
`endif

  assign w_mismatch = (r_state == ST_CMP) && (r_res1 != r_res2);
  assign w_fcnt_sat = &r_fault_cnt;

  // Controller FSM plus the mismatch counter; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_res1      <= '0;
      r_res2      <= '0;
      r_retry_cnt <= '0;
      r_fault_cnt <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_fault <= 1'b0;
    end else begin
      if (clr_fault_cnt) begin
        r_fault_cnt <= '0;
      end else if (w_mismatch && !w_fcnt_sat) begin
        r_fault_cnt <= r_fault_cnt + FCNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_a         <= req_a;
            r_b         <= req_b;
            r_op        <= req_op;
            r_retry_cnt <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res1  <= w_lane1;
          r_res2  <= w_lane2_q;
          r_state <= ST_CMP;
        end
        ST_CMP: begin
          if (!w_mismatch) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_res1[WIDTH-1:0];
            r_rsp_carry <= r_res1[WIDTH];
            r_rsp_fault <= 1'b0;
            r_state     <= ST_RESP;
          end else if (r_retry_cnt < RETRY_W'(MAX_RETRY)) begin
            r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
            r_state     <= ST_EXEC;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_res1[WIDTH-1:0];
            r_rsp_carry <= r_res1[WIDTH];
            r_rsp_fault <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign busy        = r_busy;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_carry   = r_rsp_carry;
  assign rsp_fault   = r_rsp_fault;
  assign fault_count = r_fault_cnt;

endmodule

// File: tb/tb_alu_lockstep_ctrl.sv
// Self-checking bench for alu_lockstep_ctrl; fault-injection cases build when ALU_LOCKSTEP_FAULT_INJECT_EN is defined.
module tb_alu_lockstep_ctrl;

  localparam int NV = 10;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_fault;
  logic       busy;
  logic [7:0] fault_count;
  logic       clr_fault_cnt;
`ifdef ALU_LOCKSTEP_FAULT_INJECT_EN
  logic [8:0] inj_mask;
  logic [8:0] inj_val;
  bit         inj_persist;
  bit         busy_q;
`endif

  alu_lockstep_ctrl #(.WIDTH(8), .MAX_RETRY(2), .FCNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_carry     (rsp_carry),
    .rsp_fault     (rsp_fault),
    .busy          (busy),
    .fault_count   (fault_count),
    .clr_fault_cnt (clr_fault_cnt)
`ifdef ALU_LOCKSTEP_FAULT_INJECT_EN
    ,
    .inj_mask      (inj_mask)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [8:0] res;
    int         hold;
    bit         early;
  } vec_t;

  typedef struct packed {
    logic [8:0] res;
    logic       fault;
  } exp_t;

  vec_t       vecs [NV];
  exp_t       sb [$];
  int         checks;
  int         failures;
  logic [7:0] exp_fc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

`ifdef ALU_LOCKSTEP_FAULT_INJECT_EN
  // Lane 2 corruption: applied in the first EXEC cycle, dropped at CMP unless persistent.
  initial begin
    inj_mask = '0;
    busy_q   = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy)             inj_mask = '0;
      else if (!busy_q)      inj_mask = inj_val;
      else if (!inj_persist) inj_mask = '0;
      busy_q = busy;
    end
  end
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int unsigned ia = a;
    int unsigned ib = b;
    case (op)
      2'd0:    return 9'((ia + ib) & 32'h1FF);
      2'd1:    return 9'((ia - ib) & 32'h1FF);
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [8:0] res, input bit fault, input int lat_exp,
                        input int hold, input bit early, input bit clr);
    int   lat;
    int   n;
    exp_t e;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid     = 1'b1;
    req_a         = a;
    req_b         = b;
    req_op        = op;
    clr_fault_cnt = clr;
    sb.push_back('{res: res, fault: fault});
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = early;
    lat       = 1;
    chk("busy_active", 32'(busy), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    while (!rsp_valid && lat < 40) begin
      if (lat == 2) rsp_ready = 1'b0;
      @(negedge clk);
      lat++;
    end
    rsp_ready = 1'b0;
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      clr_fault_cnt = 1'b0;
      return;
    end
    chk("latency", 32'(lat), 32'(lat_exp));
    if (clr) begin
      exp_fc = '0;
    end else begin
      n = (lat_exp - 3) / 2 + (fault ? 1 : 0);
      for (int i = 0; i < n; i++) if (exp_fc != 8'hFF) exp_fc = exp_fc + 8'd1;
    end
    chk("fault_count", 32'(fault_count), 32'(exp_fc));
    clr_fault_cnt = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(res[7:0]));
      chk("hold_carry", 32'(rsp_carry), 32'(res[8]));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    e = sb.pop_front();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(e.res[7:0]));
    chk("rsp_carry", 32'(rsp_carry), 32'(e.res[8]));
    chk("rsp_fault", 32'(rsp_fault), 32'(e.fault));
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    int   seen;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] rop;

    checks        = 0;
    failures      = 0;
    exp_fc        = '0;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_a         = '0;
    req_b         = '0;
    req_op        = '0;
    rsp_ready     = 1'b0;
    clr_fault_cnt = 1'b0;
`ifdef ALU_LOCKSTEP_FAULT_INJECT_EN
    inj_val       = '0;
    inj_persist   = 1'b0;
`endif

    vecs[0] = '{8'hF0, 8'h20, 2'b00, 9'h110, 0, 1'b0};
    vecs[1] = '{8'h05, 8'h07, 2'b01, 9'h1FE, 4, 1'b0};
    vecs[2] = '{8'hA5, 8'h0F, 2'b10, 9'h005, 0, 1'b1};
    vecs[3] = '{8'hA5, 8'h0F, 2'b11, 9'h0AF, 1, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 2'b00, 9'h100, 0, 1'b0};
    vecs[5] = '{8'h07, 8'h05, 2'b01, 9'h002, 2, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 2'b01, 9'h000, 0, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 2'b00, 9'h1FE, 3, 1'b0};
    vecs[8] = '{8'h3C, 8'hC3, 2'b11, 9'h0FF, 0, 1'b0};
    vecs[9] = '{8'h80, 8'h81, 2'b01, 9'h1FF, 0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault_count", 32'(fault_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      do_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, 1'b0, 3,
             vecs[i].hold, vecs[i].early, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 2'($urandom_range(0, 3));
      do_txn(ra, rb, rop, model(ra, rb, rop), 1'b0, 3,
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    do_txn(8'h11, 8'h22, 2'b00, 9'h033, 1'b0, 3, 0, 1'b0, 1'b1);

`ifdef ALU_LOCKSTEP_FAULT_INJECT_EN
    inj_val = 9'h001; inj_persist = 1'b0;
    do_txn(8'hF0, 8'h20, 2'b00, 9'h110, 1'b0, 5, 0, 1'b0, 1'b0);
    inj_val = 9'h100; inj_persist = 1'b1;
    do_txn(8'h05, 8'h07, 2'b01, 9'h1FE, 1'b1, 7, 2, 1'b0, 1'b0);
    do_txn(8'hC0, 8'h0C, 2'b11, 9'h0CC, 1'b1, 7, 0, 1'b0, 1'b1);
    do_txn(8'hC0, 8'h0C, 2'b10, 9'h000, 1'b1, 7, 0, 1'b0, 1'b0);
    while (exp_fc != 8'hFF && checks < 5000) begin
      do_txn(8'h12, 8'h34, 2'b00, 9'h046, 1'b1, 7, 0, 1'b0, 1'b0);
    end
    do_txn(8'h12, 8'h34, 2'b00, 9'h046, 1'b1, 7, 0, 1'b0, 1'b0);
    inj_val = '0; inj_persist = 1'b0;
`endif

    req_valid = 1'b1;
    req_a     = 8'h44;
    req_b     = 8'h55;
    req_op    = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    exp_fc = '0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_fault_count", 32'(fault_count), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("mid_rst_no_rsp", 32'(seen), 32'd0);

    do_txn(8'h07, 8'h05, 2'b01, 9'h002, 1'b0, 3, 1, 1'b0, 1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
